// File: rtl/bhupura_ingress_gateway.sv
// Host-side request FIFO and single-outstanding issue/response stage in front of the Bhupura NoC port.
// Optional feature: define GATEWAY_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module bhupura_ingress_gateway #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DATA_WIDTH-1:0]      req_data,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic                       resp_err,
  output logic [DATA_WIDTH-1:0]      noc_data,
  output logic [ADDR_WIDTH-1:0]      noc_addr,
  output logic                       noc_valid,
  input  logic [DATA_WIDTH-1:0]      noc_data_in,
  input  logic                       noc_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("bhupura_ingress_gateway: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  push;
  logic                  pop;

`ifdef GATEWAY_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`endif

  // A full FIFO refuses the host even when the FSM pops in the same cycle.
  assign full       = (level == LVL_W'(DEPTH));
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign pop        = (state == S_IDLE) && (level != '0);
  assign fifo_level = level;
  assign busy       = (state != S_IDLE);

  // NOTE: storage is deliberately not reset; the pointers and level alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= req_data;
      mem_addr[wr_ptr] <= req_addr;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      noc_valid  <= 1'b0;
      noc_data   <= '0;
      noc_addr   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
`ifdef GATEWAY_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (level != '0) begin
            noc_data  <= mem_data[rd_ptr];
            noc_addr  <= mem_addr[rd_ptr];
            noc_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          noc_valid <= 1'b0;
          state     <= S_WAIT;
`ifdef GATEWAY_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        S_WAIT: begin
          // A ready seen on the expiry cycle still completes the request normally.
          if (noc_ready) begin
            resp_data  <= noc_data_in;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
`ifdef GATEWAY_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bhupura_ingress_gateway.sv
// Bench for bhupura_ingress_gateway: directed steps plus random traffic against a transaction-level queue model.
`timescale 1ns/1ps
module tb_bhupura_ingress_gateway;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_data;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic [DW-1:0] noc_data;
  logic [AW-1:0] noc_addr;
  logic          noc_valid;
  logic [DW-1:0] noc_data_in;
  logic          noc_ready;
  logic [LW-1:0] fifo_level;
  logic          busy;

  always #5 clk = ~clk;

  // The fake NoC answers with a fixed value or with a function of the address it was given.
  logic          use_fixed;
  logic [DW-1:0] fixed_val;

  function automatic logic [DW-1:0] noc_model(input logic [AW-1:0] a);
    return {a ^ 32'hC3C3_3C3C, ~a};
  endfunction

  assign noc_data_in = use_fixed ? fixed_val : noc_model(noc_addr);

  bhupura_ingress_gateway #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .noc_data(noc_data), .noc_addr(noc_addr), .noc_valid(noc_valid),
    .noc_data_in(noc_data_in), .noc_ready(noc_ready),
    .fifo_level(fifo_level), .busy(busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } resp_t;

  req_t  exp_q[$];
  resp_t out_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    accepted, issued, responded, prev_out;
  logic  prev_nv;
  logic  tmo_mode;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req();
    req_data = {$urandom, $urandom};
    req_addr = $urandom;
  endtask

  task automatic model_clear();
    exp_q.delete();
    out_q.delete();
    accepted  = 0;
    issued    = 0;
    responded = 0;
    prev_out  = 0;
    prev_nv   = 1'b0;
  endtask

  // One clock: score the edge's handshakes, then check the post-edge state against the model.
  task automatic cycle();
    logic          acc, hs, stall;
    logic [DW-1:0] rd_pre;
    req_t          r;
    resp_t         e;
    acc    = req_valid && req_ready;
    r      = '{addr: req_addr, data: req_data};
    hs     = resp_valid && resp_ready;
    stall  = resp_valid && !resp_ready;
    rd_pre = resp_data;
    if (hs) begin
      if (out_q.size() == 0) begin
        check("resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = out_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_err", 64'(resp_err), 64'(e.err));
        responded++;
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back(r);
      accepted++;
    end
    if (stall) begin
      check("resp_hold_valid", 64'(resp_valid), 64'd1);
      check("resp_hold_data", resp_data, rd_pre);
    end
    if (noc_valid) begin
      check("issue_pulse_width", 64'(prev_nv), 64'd0);
      check("issue_while_busy", 64'(prev_out), 64'd0);
      if (exp_q.size() == 0) begin
        check("issue_spurious", 64'd1, 64'd0);
      end else begin
        r = exp_q.pop_front();
        check("noc_data", noc_data, r.data);
        check("noc_addr", 64'(noc_addr), 64'(r.addr));
        e.err  = tmo_mode;
        e.data = tmo_mode ? '0 : (use_fixed ? fixed_val : noc_model(r.addr));
        out_q.push_back(e);
        issued++;
      end
    end
    check("fifo_level", 64'(fifo_level), 64'(accepted - issued));
    check("busy", 64'(busy), 64'(issued != responded));
    check("req_ready", 64'(req_ready), 64'((accepted - issued) < DEPTH));
    prev_nv  = noc_valid;
    prev_out = issued - responded;
  endtask

  task automatic drain(input int budget);
    req_valid  = 1'b0;
    noc_ready  = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < budget && (responded != accepted); i++) cycle();
    check("drain_complete", 64'(responded), 64'(accepted));
  endtask

  initial begin
    int base;
    int a0;
    req_valid  = 1'b0;
    req_data   = '0;
    req_addr   = '0;
    resp_ready = 1'b0;
    noc_ready  = 1'b0;
    use_fixed  = 1'b0;
    fixed_val  = '0;
    tmo_mode   = 1'b0;
    model_clear();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_noc_valid", 64'(noc_valid), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_noc_data", noc_data, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request with exact latency
    use_fixed = 1'b1;
    fixed_val = 64'h1234;
    noc_ready = 1'b1;
    req_valid = 1'b1;
    req_data  = 64'hA5A5;
    req_addr  = 32'h10;
    cycle();
    req_valid = 1'b0;
    check("t2_noc_valid_e0", 64'(noc_valid), 64'd0);
    cycle();
    check("t2_noc_valid_e1", 64'(noc_valid), 64'd1);
    check("t2_noc_data", noc_data, 64'hA5A5);
    check("t2_noc_addr", 64'(noc_addr), 64'h10);
    cycle();
    check("t2_noc_valid_e2", 64'(noc_valid), 64'd0);
    check("t2_resp_valid_e2", 64'(resp_valid), 64'd0);
    cycle();
    check("t2_resp_valid_e3", 64'(resp_valid), 64'd1);
    check("t2_resp_data", resp_data, 64'h1234);
    check("t2_resp_err", 64'(resp_err), 64'd0);
    resp_ready = 1'b1;
    cycle();
    check("t2_resp_done", 64'(resp_valid), 64'd0);
    resp_ready = 1'b0;
    use_fixed  = 1'b0;

    // Asynchronous reset mid-WAIT with one more request queued
    noc_ready = 1'b0;
    req_valid = 1'b1;
    new_req();
    cycle();
    new_req();
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    check("t1_busy_before_rst", 64'(busy), 64'd1);
    check("t1_level_before_rst", 64'(fifo_level), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_noc_valid", 64'(noc_valid), 64'd0);
    check("t1_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("t1_rst_busy", 64'(busy), 64'd0);
    check("t1_rst_level", 64'(fifo_level), 64'd0);
    check("t1_rst_noc_addr", 64'(noc_addr), 64'd0);
    check("t1_rst_resp_err", 64'(resp_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    noc_ready  = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("t1_no_stale_resp", 64'(resp_valid), 64'd0);
      check("t1_no_stale_issue", 64'(noc_valid), 64'd0);
    end

    // Fill and backpressure
    noc_ready  = 1'b0;
    resp_ready = 1'b0;
    base       = accepted;
    req_valid  = 1'b1;
    new_req();
    for (int i = 0; i < 20 && (accepted - base) < 5; i++) begin
      a0 = accepted;
      cycle();
      if (accepted != a0) new_req();
    end
    check("t3_level_full", 64'(fifo_level), 64'(DEPTH));
    check("t3_req_ready_low", 64'(req_ready), 64'd0);
    for (int i = 0; i < 5; i++) cycle();
    check("t3_sixth_blocked", 64'(accepted - base), 64'd5);
    noc_ready  = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 40 && (accepted - base) < 6; i++) cycle();
    check("t3_sixth_accepted", 64'(accepted - base), 64'd6);
    drain(100);

    // Response stall, then simultaneous push/pop at level 1
    noc_ready  = 1'b1;
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    new_req();
    cycle();
    new_req();
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !resp_valid; i++) cycle();
    check("t4_resp_arrives", 64'(resp_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t4_stall_no_issue", 64'(noc_valid), 64'd0);
    end
    check("t4_stall_level", 64'(fifo_level), 64'd1);
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    new_req();
    cycle();
    req_valid = 1'b0;
    check("t5_pushpop_level", 64'(fifo_level), 64'd1);
    check("t5_pushpop_issue", 64'(noc_valid), 64'd1);
    drain(100);

    // Random traffic, exercising pointer wrap many times
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 2) != 0);
      noc_ready  = ($urandom_range(0, 3) != 0);
      resp_ready = $urandom_range(0, 1) == 1;
      new_req();
      cycle();
    end
    drain(200);
    check("rand_wrap_exercised", 64'(accepted > 2 * DEPTH + 1), 64'd1);

`ifdef GATEWAY_TIMEOUT_EN
    // Expiry after TMO wait cycles, then ready on the last wait cycle wins
    tmo_mode   = 1'b1;
    noc_ready  = 1'b0;
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    new_req();
    cycle();
    req_valid = 1'b0;
    cycle();
    check("t6_issue", 64'(noc_valid), 64'd1);
    for (int i = 0; i < TMO; i++) begin
      cycle();
      check("t6_wait_no_resp", 64'(resp_valid), 64'd0);
    end
    cycle();
    check("t6_tmo_resp_valid", 64'(resp_valid), 64'd1);
    check("t6_tmo_err", 64'(resp_err), 64'd1);
    check("t6_tmo_data", resp_data, 64'd0);
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    tmo_mode   = 1'b0;
    req_valid  = 1'b1;
    new_req();
    cycle();
    req_valid = 1'b0;
    cycle();
    check("t6b_issue", 64'(noc_valid), 64'd1);
    for (int i = 0; i < TMO; i++) begin
      cycle();
      check("t6b_wait_no_resp", 64'(resp_valid), 64'd0);
    end
    noc_ready = 1'b1;
    cycle();
    check("t6b_resp_valid", 64'(resp_valid), 64'd1);
    check("t6b_err_clear", 64'(resp_err), 64'd0);
    drain(20);
`else
    // Without the timeout, WAIT holds indefinitely
    noc_ready  = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    new_req();
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 3 * TMO; i++) begin
      cycle();
      check("notmo_wait_holds", 64'(resp_valid), 64'd0);
    end
    check("notmo_busy", 64'(busy), 64'd1);
    drain(20);
    check("notmo_err_zero", 64'(resp_err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

endmodule
